sgd_update_engine: RTL and testbench

SGD_UPDATE_ENGINE -- requirements
Module: sgd_update_engine

---
 rtl/sgd_update_engine.sv | 82 ++++++++
 tb/tb_sgd_update_engine.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sgd_update_engine.sv
// sgd_update_engine: streaming per-lane SGD update y = x +/- (dx >>> lr) with saturation
module sgd_update_engine #(
  parameter int DATA_W = 16,
  parameter int LANES = 4,
  parameter int LEN_W = 8,
  parameter int LR_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LEN_W-1:0]          len,
  input  logic                      mode,
  input  logic [LR_W-1:0]           learning_rate,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_x,
  input  logic [LANES*DATA_W-1:0]   in_dx,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_y,
  output logic                      busy,
  output logic                      done,
  output logic                      sat_flag
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [LEN_W-1:0] len_q, acc_cnt, out_cnt;
  logic mode_q;
  logic [LR_W-1:0] lr_q;
  logic [LANES*DATA_W-1:0] y_n;
  logic [LANES-1:0] sat_n;
  logic acc, hs;
  assign acc = in_valid && in_ready;
  assign hs = out_valid && out_ready;
  assign in_ready = (state == RUN) && (acc_cnt < len_q) && (!out_valid || out_ready);
  assign busy = state != IDLE;
  assign done = state == DONE;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [DATA_W-1:0] x, dx, sh;
    logic [DATA_W:0] s;
    assign x = in_x[g*DATA_W +: DATA_W];
    assign dx = in_dx[g*DATA_W +: DATA_W];
    assign sh = dx >>> lr_q;
    assign s = mode_q ? {x[DATA_W-1], x} - {sh[DATA_W-1], sh} : {x[DATA_W-1], x} + {sh[DATA_W-1], sh};
    assign sat_n[g] = s[DATA_W] ^ s[DATA_W-1];
    assign y_n[g*DATA_W +: DATA_W] = sat_n[g] ? {s[DATA_W], {(DATA_W-1){~s[DATA_W]}}} : s[DATA_W-1:0];
  end
  // pass control, output register and sticky saturation tracking
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      len_q <= '0;
      mode_q <= 1'b0;
      lr_q <= '0;
      acc_cnt <= '0;
      out_cnt <= '0;
      out_valid <= 1'b0;
      out_y <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (acc) begin
        out_valid <= 1'b1;
        out_y <= y_n;
        acc_cnt <= acc_cnt + LEN_W'(1);
        if (|sat_n) sat_flag <= 1'b1;
      end else if (hs) out_valid <= 1'b0;
      if (hs) out_cnt <= out_cnt + LEN_W'(1);
      case (state)
        IDLE: if (start) begin
          len_q <= len;
          mode_q <= mode;
          lr_q <= learning_rate;
          acc_cnt <= '0;
          out_cnt <= '0;
          sat_flag <= 1'b0;
          state <= (len != '0) ? RUN : DONE;
        end
        RUN: if (hs && out_cnt == len_q - LEN_W'(1)) state <= DONE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sgd_update_engine.sv
// tb_sgd_update_engine: directed checks of the SGD update engine
module tb_sgd_update_engine;
  logic clk = 0, rst = 1, start = 0, mode = 0, in_valid = 0, out_ready = 0;
  logic [7:0] len = 0;
  logic [4:0] learning_rate = 0;
  logic [63:0] in_x = 0, in_dx = 0, out_y;
  logic in_ready, out_valid, busy, done, sat_flag;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  sgd_update_engine #(.DATA_W(16), .LANES(4), .LEN_W(8), .LR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .mode(mode),
    .learning_rate(learning_rate), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_dx(in_dx), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .busy(busy), .done(done), .sat_flag(sat_flag)
  );
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask
  function automatic logic [63:0] rep(input logic [15:0] v);
    return {4{v}};
  endfunction
  task automatic check_idle_zero(input string tag);
    chk({tag, "_rdy"}, in_ready, 0);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sat"}, sat_flag, 0);
    chk({tag, "_y"}, out_y, 0);
  endtask
  task automatic start_pass(input logic [7:0] l, input logic m, input logic [4:0] r);
    @(negedge clk);
    start = 1; len = l; mode = m; learning_rate = r;
    @(negedge clk);
    start = 0;
  endtask
  task automatic one_beat(input string tag, input logic m, input logic [4:0] r,
                          input logic [63:0] x, input logic [63:0] dx,
                          input logic [63:0] y, input logic s);
    start_pass(8'd1, m, r);
    in_x = x; in_dx = dx; in_valid = 1; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    chk({tag, "_ov"}, out_valid, 1);
    chk({tag, "_y"}, out_y, y);
    chk({tag, "_sat"}, sat_flag, s);
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    @(negedge clk);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [3:0] pat;
    int k, outs, dn;
    logic a, h, prev_stall;
    logic [63:0] prev_y;
    #12;
    check_idle_zero("reset");
    @(negedge clk);
    rst = 0;
    // three beats of 100 + (16>>>2)
    start_pass(8'd3, 1'b0, 5'd2);
    in_x = rep(16'd100); in_dx = rep(16'd16); in_valid = 1; out_ready = 1;
    chk("p1_rdy", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("p1_ov", out_valid, 1);
      chk("p1_y", out_y, rep(16'd104));
    end
    chk("p1_rdy_end", in_ready, 0);
    in_valid = 0;
    @(negedge clk);
    chk("p1_done", done, 1);
    chk("p1_busy", busy, 1);
    @(negedge clk);
    chk("p1_done_off", done, 0);
    chk("p1_busy_off", busy, 0);
    chk("p1_sat", sat_flag, 0);
    // saturation and large shifts
    one_beat("satlo", 1'b1, 5'd0, rep(16'h8000), rep(16'd1), rep(16'h8000), 1'b1);
    one_beat("sathi", 1'b0, 5'd0, rep(16'h7FFF), rep(16'd1), rep(16'h7FFF), 1'b1);
    one_beat("bigneg", 1'b0, 5'd20, rep(16'd10), rep(16'hFFFB), rep(16'd9), 1'b0);
    one_beat("bigpos", 1'b0, 5'd20, rep(16'd10), rep(16'd5), rep(16'd10), 1'b0);
    one_beat("lanes", 1'b0, 5'd1, {16'hFFFB, 16'h7FF8, 16'hFC18, 16'h03E8},
             {16'h0003, 16'h0064, 16'hFFF8, 16'h0008},
             {16'hFFFC, 16'h7FFF, 16'hFC14, 16'h03EC}, 1'b1);
    one_beat("sub", 1'b1, 5'd3, rep(16'd500), rep(16'hFFB0), rep(16'd510), 1'b0);
    // backpressure with out_ready cycling 1,0,0,1
    pat = 4'b1001;
    start_pass(8'd4, 1'b0, 5'd0);
    k = 0; outs = 0; dn = 0; prev_stall = 0; prev_y = 0;
    in_x = rep(16'd10); in_dx = rep(16'd1); in_valid = 1;
    mode = 1; learning_rate = 5'd7;
    for (int c = 0; c < 40 && dn == 0; c++) begin
      out_ready = pat[c % 4];
      #1;
      if (prev_stall) chk("stall_hold", out_y, prev_y);
      if (out_valid) chk("stall_y", out_y, rep(16'(10 * outs + 11)));
      if (k == 4) chk("no_rdy", in_ready, 0);
      if (done) dn++;
      a = in_valid && in_ready;
      h = out_valid && out_ready;
      prev_stall = out_valid && !out_ready;
      prev_y = out_y;
      @(posedge clk);
      #1;
      if (a) begin
        k++;
        in_x = rep(16'(10 * k + 10));
        if (k == 4) in_valid = 0;
      end
      if (h) outs++;
      @(negedge clk);
    end
    chk("stall_outs", outs, 4);
    chk("stall_accs", k, 4);
    chk("stall_done", dn, 1);
    out_ready = 1;
    @(negedge clk);
    // zero-length pass
    in_valid = 1;
    start_pass(8'd0, 1'b0, 5'd0);
    chk("z_busy", busy, 1);
    chk("z_done", done, 1);
    chk("z_rdy", in_ready, 0);
    @(negedge clk);
    chk("z_busy_off", busy, 0);
    chk("z_done_off", done, 0);
    chk("z_rdy_off", in_ready, 0);
    in_valid = 0;
    // reset mid-pass
    start_pass(8'd5, 1'b0, 5'd0);
    in_x = rep(16'h7FFF); in_dx = rep(16'd1); in_valid = 1; out_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_sat", sat_flag, 1);
    rst = 1;
    #1;
    check_idle_zero("abort");
    in_valid = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("abort_nodone", done, 0);
    chk("abort_busy", busy, 0);
    one_beat("clean", 1'b0, 5'd0, rep(16'd5), rep(16'd2), rep(16'd7), 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
